// File: rtl/key_digit_buffer_if.sv
// Keyboard-event inputs and display/commit outputs of key_digit_buffer.
// master drives key events (decoder side); slave is the buffer itself.
interface key_digit_buffer_if;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [3:0]   bcd;
  logic [3:0]   ssd_ctl;
  logic [15:0]  value;
  logic         value_valid;
  logic [2:0]   digit_count;

  modport master (
    output key_valid, last_change, key_down,
    input  bcd, ssd_ctl, value, value_valid, digit_count
  );

  modport slave (
    input  key_valid, last_change, key_down,
    output bcd, ssd_ctl, value, value_valid, digit_count
  );
endinterface

// File: rtl/key_digit_buffer.sv
// Collects PS/2 digit make-codes into a 4-digit BCD entry with backspace, clear
// and commit, and time-multiplexes entry or committed value onto a 4-digit SSD.
module key_digit_buffer #(
  parameter int SCAN_BITS = 17
) (
  input  logic            clk,
  input  logic            rst,
  key_digit_buffer_if.slave bus
);

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_DIGIT,
    KEY_BKSP,
    KEY_ENTER,
    KEY_ESC
  } key_cmd_e;

  logic                 key_valid_q, key_valid_d;
  logic [15:0]          entry_q, entry_d;
  logic [2:0]           count_q, count_d;
  logic [15:0]          value_q, value_d;
  logic                 value_valid_q, value_valid_d;
  logic [SCAN_BITS-1:0] scan_q, scan_d;

  key_cmd_e   key_cmd;
  logic [3:0] key_digit;
  logic       press;
  logic [1:0] sel;

  // A press is the rising edge of key_valid on a make event.
  assign press = bus.key_valid & ~key_valid_q & bus.key_down[bus.last_change];

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    key_cmd   = KEY_NONE;
    key_digit = 4'h0;
    if (!bus.last_change[8]) begin
      unique case (bus.last_change[7:0])
        8'h45:   begin key_cmd = KEY_DIGIT; key_digit = 4'd0; end
        8'h16:   begin key_cmd = KEY_DIGIT; key_digit = 4'd1; end
        8'h1E:   begin key_cmd = KEY_DIGIT; key_digit = 4'd2; end
        8'h26:   begin key_cmd = KEY_DIGIT; key_digit = 4'd3; end
        8'h25:   begin key_cmd = KEY_DIGIT; key_digit = 4'd4; end
        8'h2E:   begin key_cmd = KEY_DIGIT; key_digit = 4'd5; end
        8'h36:   begin key_cmd = KEY_DIGIT; key_digit = 4'd6; end
        8'h3D:   begin key_cmd = KEY_DIGIT; key_digit = 4'd7; end
        8'h3E:   begin key_cmd = KEY_DIGIT; key_digit = 4'd8; end
        8'h46:   begin key_cmd = KEY_DIGIT; key_digit = 4'd9; end
        8'h66:   key_cmd = KEY_BKSP;
        8'h5A:   key_cmd = KEY_ENTER;
        8'h76:   key_cmd = KEY_ESC;
        default: key_cmd = KEY_NONE;
      endcase
    end
  end

  always_comb begin
    key_valid_d   = bus.key_valid;
    entry_d       = entry_q;
    count_d       = count_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    scan_d        = scan_q + SCAN_BITS'(1);

    if (press) begin
      unique case (key_cmd)
        KEY_DIGIT: begin
          if (count_q < 3'd4) begin
            entry_d = {entry_q[11:0], key_digit};
            count_d = count_q + 3'd1;
          end
        end
        KEY_BKSP: begin
          if (count_q != 3'd0) begin
            entry_d = {4'h0, entry_q[15:4]};
            count_d = count_q - 3'd1;
          end
        end
        KEY_ENTER: begin
          value_d       = entry_q;
          value_valid_d = 1'b1;
          entry_d       = 16'h0000;
          count_d       = 3'd0;
        end
        KEY_ESC: begin
          entry_d = 16'h0000;
          count_d = 3'd0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q   <= 1'b0;
      entry_q       <= 16'h0000;
      count_q       <= 3'd0;
      value_q       <= 16'h0000;
      value_valid_q <= 1'b0;
      scan_q        <= '0;
    end else begin
      key_valid_q   <= key_valid_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      scan_q        <= scan_d;
    end
  end

  // Entry view blanks unused leading digits; an empty entry shows the committed value.
  assign sel = scan_q[SCAN_BITS-1 -: 2];

  always_comb begin
    if (count_q == 3'd0) begin
      bus.bcd = value_q[{sel, 2'b00} +: 4];
    end else if ({1'b0, sel} >= count_q) begin
      bus.bcd = 4'hF;
    end else begin
      bus.bcd = entry_q[{sel, 2'b00} +: 4];
    end
  end

  assign bus.ssd_ctl     = ~(4'b0001 << sel);
  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.digit_count = count_q;

endmodule
